// File: rtl/sipo_deserializer_if.sv
// Handshake bundle between the serial source / word consumer and the deserializer.
// slave is the deserializer side; master is the side driving bits and ready.
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CntW = $clog2(WIDTH);

    logic             d;
    logic             d_en;
    logic             ready;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             overrun;
    logic [CntW-1:0]  bit_cnt;

    modport slave (
        input  d,
        input  d_en,
        input  ready,
        output data_out,
        output valid,
        output overrun,
        output bit_cnt
    );

    modport master (
        output d,
        output d_en,
        output ready,
        input  data_out,
        input  valid,
        input  overrun,
        input  bit_cnt
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: frames WIDTH-bit words with a bit counter and
// presents each word in a one-entry holding register with valid/ready and sticky overrun.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_deserializer_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic [CntW-1:0]  r_cnt;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shift_next;
    logic             w_complete;

    // The completed word must include the bit arriving on the completing edge.
    always_comb begin
        w_shift_next = r_shift;
        if (MSB_FIRST) begin
            w_shift_next = {r_shift[WIDTH-2:0], bus.d};
        end else begin
            w_shift_next = {bus.d, r_shift[WIDTH-1:1]};
        end
    end

    assign w_complete = bus.d_en && (r_cnt == CntW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StEmpty;
            r_shift   <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (bus.d_en) begin
                r_shift <= w_shift_next;
                r_cnt   <= w_complete ? '0 : r_cnt + CntW'(1);
            end

            unique case (r_state)
                StEmpty: begin
                    if (w_complete) begin
                        r_state <= StFull;
                        r_data  <= w_shift_next;
                    end
                end
                StFull: begin
                    if (w_complete) begin
                        // Consumer taking the old word frees the slot for the new one.
                        if (bus.ready) begin
                            r_data <= w_shift_next;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else if (bus.ready) begin
                        r_state <= StEmpty;
                    end
                end
                default: r_state <= StEmpty;
            endcase
        end
    end

    assign bus.data_out = r_data;
    assign bus.valid    = (r_state == StFull);
    assign bus.overrun  = r_overrun;
    assign bus.bit_cnt  = r_cnt;
endmodule
